// File: rtl/lfsrent_postproc.sv
// Entropy post-processor: repetition-count health test, warm-up discard,
// XOR-fold conditioning and a valid/ready output register.
module lfsrent_postproc #(
   parameter int RNG_WIDTH    = 32,
   parameter int FOLD         = 4,
   parameter int WARMUP_WORDS = 16,
   parameter int RCT_CUTOFF   = 8
) (
   input  logic                 i_clk,
   input  logic                 ff_reset,
   input  logic                 i_en,
   input  logic                 i_clear,
   input  logic [RNG_WIDTH-1:0] i_raw,
   input  logic                 i_raw_valid,
   output logic [RNG_WIDTH-1:0] o_data,
   output logic                 o_valid,
   input  logic                 i_ready,
   output logic                 o_alarm,
   output logic                 o_overrun,
   output logic                 o_warm
);

   typedef enum logic [1:0] {
      WARMUP = 2'd0,
      RUN    = 2'd1,
      ALARM  = 2'd2
   } state_t;

   localparam logic [15:0] WU_N    = 16'(WARMUP_WORDS);
   localparam logic [7:0]  FOLD_M1 = 8'(FOLD - 1);
   localparam logic [7:0]  CUT     = 8'(RCT_CUTOFF);

   state_t               state;
   logic [15:0]          warm_cnt;
   logic [7:0]           fold_cnt;
   logic [7:0]           rep_cnt;
   logic [RNG_WIDTH-1:0] acc;
   logic [RNG_WIDTH-1:0] prev;

   logic                 sample;
   logic [7:0]           rep_nxt;
   logic                 trip;
   logic                 warm_last;
   logic                 fold_done;
   logic [RNG_WIDTH-1:0] acc_nxt;

   assign sample = i_en & i_raw_valid;

   // rep_cnt==0 marks the first sample since reset, clear or enable
   always_comb begin
      rep_nxt = 8'd1;
      if (rep_cnt != 8'd0 && i_raw == prev) begin
         if (rep_cnt >= CUT) rep_nxt = CUT;
         else                rep_nxt = rep_cnt + 8'd1;
      end
   end

   assign trip      = sample && (rep_nxt >= CUT);
   assign warm_last = (warm_cnt + 16'd1) == WU_N;
   assign fold_done = fold_cnt == FOLD_M1;
   assign acc_nxt   = acc ^ i_raw;
   assign o_warm    = (state == WARMUP);

   always_ff @(posedge i_clk or posedge ff_reset) begin
      if (ff_reset) begin
         state     <= WARMUP;
         warm_cnt  <= '0;
         fold_cnt  <= '0;
         rep_cnt   <= '0;
         acc       <= '0;
         prev      <= '0;
         o_data    <= '0;
         o_valid   <= 1'b0;
         o_alarm   <= 1'b0;
         o_overrun <= 1'b0;
      end else begin
         o_overrun <= 1'b0;
         if (o_valid && i_ready) o_valid <= 1'b0;
         if (i_clear) begin
            state    <= WARMUP;
            o_alarm  <= 1'b0;
            o_valid  <= 1'b0;
            warm_cnt <= '0;
            fold_cnt <= '0;
            rep_cnt  <= '0;
            acc      <= '0;
         end else begin
            unique case (state)
               WARMUP, RUN: begin
                  if (!i_en) begin
                     state    <= WARMUP;
                     warm_cnt <= '0;
                     fold_cnt <= '0;
                     rep_cnt  <= '0;
                     acc      <= '0;
                  end else if (trip) begin
                     // alarm beats a fold completing in the same cycle
                     state    <= ALARM;
                     o_alarm  <= 1'b1;
                     o_valid  <= 1'b0;
                     o_data   <= '0;
                     acc      <= '0;
                     fold_cnt <= '0;
                     rep_cnt  <= rep_nxt;
                     prev     <= i_raw;
                  end else begin
                     if (sample) begin
                        rep_cnt <= rep_nxt;
                        prev    <= i_raw;
                     end
                     if (state == WARMUP) begin
                        if (WU_N == 16'd0) begin
                           state <= RUN;
                        end else if (sample) begin
                           if (warm_last) begin
                              state    <= RUN;
                              warm_cnt <= '0;
                           end else begin
                              warm_cnt <= warm_cnt + 16'd1;
                           end
                        end
                     end else if (sample) begin
                        if (fold_done) begin
                           acc      <= '0;
                           fold_cnt <= '0;
                           if (!o_valid || i_ready) begin
                              o_data  <= acc_nxt;
                              o_valid <= 1'b1;
                           end else begin
                              o_overrun <= 1'b1;
                           end
                        end else begin
                           acc      <= acc_nxt;
                           fold_cnt <= fold_cnt + 8'd1;
                        end
                     end
                  end
               end
               default: begin
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_lfsrent_postproc.sv
// Directed-vector bench for lfsrent_postproc with
// FOLD=4, WARMUP_WORDS=8, RCT_CUTOFF=4.
module tb_lfsrent_postproc;

   logic        i_clk;
   logic        ff_reset;
   logic        i_en;
   logic        i_clear;
   logic [31:0] i_raw;
   logic        i_raw_valid;
   logic [31:0] o_data;
   logic        o_valid;
   logic        i_ready;
   logic        o_alarm;
   logic        o_overrun;
   logic        o_warm;

   int tests;
   int errors;

   localparam logic [31:0] A = 32'hA5A5A5A5;
   localparam logic [31:0] B = 32'h5A5A5A5A;

   lfsrent_postproc #(
      .RNG_WIDTH(32),
      .FOLD(4),
      .WARMUP_WORDS(8),
      .RCT_CUTOFF(4)
   ) dut (
      .i_clk(i_clk),
      .ff_reset(ff_reset),
      .i_en(i_en),
      .i_clear(i_clear),
      .i_raw(i_raw),
      .i_raw_valid(i_raw_valid),
      .o_data(o_data),
      .o_valid(o_valid),
      .i_ready(i_ready),
      .o_alarm(o_alarm),
      .o_overrun(o_overrun),
      .o_warm(o_warm)
   );

   initial begin
      i_clk = 1'b0;
      forever #5 i_clk = ~i_clk;
   end

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic smp(input logic [31:0] v);
      i_raw       = v;
      i_raw_valid = 1'b1;
      tick();
      i_raw_valid = 1'b0;
   endtask

   task automatic test_reset();
      ff_reset = 1'b1;
      tick();
      tests++;
      if (o_data !== 32'h0 || o_valid !== 1'b0 || o_alarm !== 1'b0 ||
          o_overrun !== 1'b0 || o_warm !== 1'b1) begin
         errors++;
         $display("FAIL reset: data=%h v=%b a=%b ov=%b w=%b exp 0/0/0/0/1",
                  o_data, o_valid, o_alarm, o_overrun, o_warm);
      end
      ff_reset = 1'b0;
      tick();
   endtask

   task automatic test_fold();
      i_en    = 1'b1;
      i_ready = 1'b1;
      for (int i = 0; i < 7; i++) smp(32'h100 + i);
      tests++;
      if (o_warm !== 1'b1) begin
         errors++;
         $display("FAIL warm_7: got %b exp 1", o_warm);
      end
      smp(32'h107);
      tests++;
      if (o_warm !== 1'b0) begin
         errors++;
         $display("FAIL warm_8: got %b exp 0", o_warm);
      end
      smp(32'h1);
      smp(32'h2);
      smp(32'h4);
      tests++;
      if (o_valid !== 1'b0) begin
         errors++;
         $display("FAIL fold_early: valid=%b exp 0", o_valid);
      end
      smp(32'h8);
      tests++;
      if (o_valid !== 1'b1 || o_data !== 32'h0000000F) begin
         errors++;
         $display("FAIL fold_word: v=%b data=%h exp 1/0000000f",
                  o_valid, o_data);
      end
      tick();
      tests++;
      if (o_valid !== 1'b0) begin
         errors++;
         $display("FAIL fold_accept: valid=%b exp 0", o_valid);
      end
   endtask

   task automatic test_overrun();
      i_ready = 1'b0;
      smp(32'h10);
      smp(32'h20);
      smp(32'h40);
      smp(32'h80);
      tests++;
      if (o_valid !== 1'b1 || o_data !== 32'hF0 || o_overrun !== 1'b0) begin
         errors++;
         $display("FAIL ovr_first: v=%b data=%h ov=%b exp 1/000000f0/0",
                  o_valid, o_data, o_overrun);
      end
      smp(32'h1);
      smp(32'h2);
      smp(32'h4);
      tests++;
      if (o_data !== 32'hF0 || o_overrun !== 1'b0) begin
         errors++;
         $display("FAIL ovr_hold: data=%h ov=%b exp 000000f0/0",
                  o_data, o_overrun);
      end
      smp(32'h8);
      tests++;
      if (o_overrun !== 1'b1 || o_data !== 32'hF0 || o_valid !== 1'b1) begin
         errors++;
         $display("FAIL ovr_pulse: ov=%b data=%h v=%b exp 1/000000f0/1",
                  o_overrun, o_data, o_valid);
      end
      tick();
      tests++;
      if (o_overrun !== 1'b0) begin
         errors++;
         $display("FAIL ovr_once: ov=%b exp 0", o_overrun);
      end
      i_ready = 1'b1;
      tick();
      tests++;
      if (o_valid !== 1'b0) begin
         errors++;
         $display("FAIL ovr_drain: valid=%b exp 0", o_valid);
      end
   endtask

   task automatic test_alarm();
      i_ready = 1'b0;
      smp(32'h11);
      smp(32'h22);
      smp(32'h44);
      smp(A);
      tests++;
      if (o_valid !== 1'b1 || o_data !== 32'hA5A5A5D2) begin
         errors++;
         $display("FAIL alarm_pre: v=%b data=%h exp 1/a5a5a5d2",
                  o_valid, o_data);
      end
      smp(A);
      smp(A);
      tests++;
      if (o_alarm !== 1'b0) begin
         errors++;
         $display("FAIL alarm_3rep: alarm=%b exp 0", o_alarm);
      end
      smp(A);
      tests++;
      if (o_alarm !== 1'b1 || o_valid !== 1'b0 || o_data !== 32'h0) begin
         errors++;
         $display("FAIL alarm_trip: a=%b v=%b data=%h exp 1/0/0",
                  o_alarm, o_valid, o_data);
      end
      for (int i = 1; i <= 5; i++) smp(32'(i));
      tests++;
      if (o_alarm !== 1'b1 || o_valid !== 1'b0 || o_warm !== 1'b0) begin
         errors++;
         $display("FAIL alarm_sticky: a=%b v=%b w=%b exp 1/0/0",
                  o_alarm, o_valid, o_warm);
      end
      i_clear = 1'b1;
      tick();
      i_clear = 1'b0;
      tests++;
      if (o_alarm !== 1'b0 || o_warm !== 1'b1) begin
         errors++;
         $display("FAIL alarm_clear: a=%b w=%b exp 0/1", o_alarm, o_warm);
      end
   endtask

   task automatic test_rct_interleave();
      i_ready = 1'b1;
      for (int i = 0; i < 8; i++) smp(32'h200 + i);
      smp(A);
      smp(A);
      smp(A);
      smp(B);
      tests++;
      if (o_valid !== 1'b1 || o_data !== 32'hFFFFFFFF) begin
         errors++;
         $display("FAIL rct_word: v=%b data=%h exp 1/ffffffff",
                  o_valid, o_data);
      end
      smp(A);
      smp(A);
      smp(A);
      tests++;
      if (o_alarm !== 1'b0 || o_warm !== 1'b0) begin
         errors++;
         $display("FAIL rct_interleave: a=%b w=%b exp 0/0", o_alarm, o_warm);
      end
   endtask

   task automatic test_en_drop();
      i_ready = 1'b1;
      i_en    = 1'b0;
      tick();
      i_en = 1'b1;
      for (int i = 0; i < 8; i++) smp(32'h300 + i);
      tests++;
      if (o_warm !== 1'b0) begin
         errors++;
         $display("FAIL en_run: w=%b exp 0", o_warm);
      end
      smp(32'h1000);
      smp(32'h2000);
      i_en = 1'b0;
      tick();
      tests++;
      if (o_warm !== 1'b1) begin
         errors++;
         $display("FAIL en_drop: w=%b exp 1", o_warm);
      end
      i_en = 1'b1;
      for (int i = 0; i < 7; i++) smp(32'h400 + i);
      tests++;
      if (o_warm !== 1'b1) begin
         errors++;
         $display("FAIL en_rewarm: w=%b exp 1", o_warm);
      end
      smp(32'h407);
      smp(32'h1);
      smp(32'h2);
      smp(32'h4);
      tests++;
      if (o_warm !== 1'b0 || o_valid !== 1'b0) begin
         errors++;
         $display("FAIL en_partial: w=%b v=%b exp 0/0", o_warm, o_valid);
      end
      smp(32'h8);
      tests++;
      if (o_valid !== 1'b1 || o_data !== 32'h0000000F) begin
         errors++;
         $display("FAIL en_word: v=%b data=%h exp 1/0000000f",
                  o_valid, o_data);
      end
      tick();
   endtask

   task automatic test_reset_mid();
      i_ready = 1'b0;
      smp(32'h10);
      smp(32'h20);
      smp(32'h40);
      smp(32'h80);
      smp(32'h1);
      smp(32'h2);
      tests++;
      if (o_valid !== 1'b1 || o_data !== 32'hF0) begin
         errors++;
         $display("FAIL mid_pre: v=%b data=%h exp 1/000000f0",
                  o_valid, o_data);
      end
      #1 ff_reset = 1'b1;
      #1;
      tests++;
      if (o_data !== 32'h0 || o_valid !== 1'b0 || o_alarm !== 1'b0 ||
          o_overrun !== 1'b0 || o_warm !== 1'b1) begin
         errors++;
         $display("FAIL mid_reset: data=%h v=%b a=%b ov=%b w=%b exp 0/0/0/0/1",
                  o_data, o_valid, o_alarm, o_overrun, o_warm);
      end
      tick();
      ff_reset = 1'b0;
      tick();
   endtask

   initial begin
      tests       = 0;
      errors      = 0;
      ff_reset    = 1'b1;
      i_en        = 1'b0;
      i_clear     = 1'b0;
      i_raw       = '0;
      i_raw_valid = 1'b0;
      i_ready     = 1'b0;
      test_reset();
      test_fold();
      test_overrun();
      test_alarm();
      test_rct_interleave();
      test_en_drop();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end

endmodule
